// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: FSM state codes, handshake
// level names and the register-bus width the divider is sized against.
package div_unit_pkg;

  // Register-bus widths of the surrounding core
  localparam int REG_BUS        = 32;
  localparam int DOUBLE_REG_BUS = 64;

  // Request / result-ready levels as seen on the execute-stage interface
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  // Divider FSM state codes
  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring-division iteration (combinational).
// The {rem,quo} pair is shifted left by one; if the widened partial remainder
// is at least the divisor it is reduced and a 1 enters the quotient LSB.
// The running remainder always stays below the divisor, so DATA_W bits hold
// it between iterations; only the compare needs the extra shifted-in bit.
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quo_o
);

  logic [DATA_W:0]   w_shift_rem;
  logic [DATA_W-1:0] w_shift_quo;
  logic              w_ge;

  // Shift, compare against the zero-extended divisor, conditionally subtract
  always_comb begin
    w_shift_rem = {rem_i, quo_i[DATA_W-1]};
    w_shift_quo = {quo_i[DATA_W-2:0], 1'b0};
    w_ge        = (w_shift_rem >= {1'b0, divisor_i});
    // The true difference is below the divisor, so its low bits are exact.
    rem_o       = w_ge ? (w_shift_rem[DATA_W-1:0] - divisor_i) : w_shift_rem[DATA_W-1:0];
    quo_o       = {w_shift_quo[DATA_W-1:1], w_ge};
  end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Handshake: the requester raises start_i with operands and holds it until
// ready_o is seen; result_o is valid only while ready_o=1 (otherwise 0) and is
// held while start_i stays high; dropping start_i returns the unit to idle on
// the next edge. annul_i aborts whatever is in flight and wins over start_i.
// Optional feature macro: DIV_EARLY_OUT_EN -- when |dividend| < |divisor| the
// result is produced straight from idle in one edge instead of 33.
// dbg_state_o exposes the FSM state for observation.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = REG_BUS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] opdata1_i,
  input  logic [DATA_W-1:0] opdata2_i,
  input  logic              start_i,
  input  logic              signed_i,
  input  logic              rem_i,
  input  logic              annul_i,
  output logic [DATA_W-1:0] result_o,
  output logic              ready_o,
  output logic [1:0]        dbg_state_o
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  div_state_t        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_quo;
  logic [DATA_W-1:0] r_divisor;   // divisor magnitude
  logic [DATA_W-1:0] r_dividend;  // original dividend, for the divide-by-zero remainder
  logic              r_rem_sel;
  logic              r_neg_quo;
  logic              r_neg_rem;
  logic [DATA_W-1:0] r_result;
  logic              r_ready;

  logic              w_sign1;
  logic              w_sign2;
  logic [DATA_W-1:0] w_mag1;
  logic [DATA_W-1:0] w_mag2;
  logic [DATA_W-1:0] w_rem_next;
  logic [DATA_W-1:0] w_quo_next;
  logic [DATA_W-1:0] w_quo_fixed;
  logic [DATA_W-1:0] w_rem_fixed;
  logic              w_abort;

  // Operand signs and magnitudes at request time, plus the final sign fix
  always_comb begin
    w_sign1     = signed_i & opdata1_i[DATA_W-1];
    w_sign2     = signed_i & opdata2_i[DATA_W-1];
    w_mag1      = w_sign1 ? ('0 - opdata1_i) : opdata1_i;
    w_mag2      = w_sign2 ? ('0 - opdata2_i) : opdata2_i;
    w_quo_fixed = r_neg_quo ? ('0 - w_quo_next) : w_quo_next;
    w_rem_fixed = r_neg_rem ? ('0 - w_rem_next) : w_rem_next;
    w_abort     = annul_i | (start_i == DIV_STOP);
  end

  div_step #(.DATA_W(DATA_W)) u_step (
    .rem_i     (r_rem),
    .quo_i     (r_quo),
    .divisor_i (r_divisor),
    .rem_o     (w_rem_next),
    .quo_o     (w_quo_next)
  );

  // Divider FSM: operand capture, iteration counter, sign fix and result hold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= DIV_FREE;
      r_cnt      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_divisor  <= '0;
      r_dividend <= '0;
      r_rem_sel  <= 1'b0;
      r_neg_quo  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_result   <= '0;
      r_ready    <= DIV_RESULT_NOT_READY;
    end else begin
      case (r_state)
        DIV_FREE: begin
          r_ready  <= DIV_RESULT_NOT_READY;
          r_result <= '0;
          if (!annul_i && start_i == DIV_START) begin
            r_divisor  <= w_mag2;
            r_dividend <= opdata1_i;
            r_rem_sel  <= rem_i;
            r_neg_quo  <= w_sign1 ^ w_sign2;
            r_neg_rem  <= w_sign1;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= w_mag1;
            if (opdata2_i == '0) begin
              r_state <= DIV_BY_ZERO;
`ifdef DIV_EARLY_OUT_EN
            end else if (w_mag1 < w_mag2) begin
              // Quotient is zero and the remainder is the dividend itself
              r_state  <= DIV_END;
              r_ready  <= DIV_RESULT_READY;
              r_result <= rem_i ? opdata1_i : '0;
`endif
            end else begin
              r_state <= DIV_ON;
            end
          end
        end

        DIV_BY_ZERO: begin
          if (annul_i) begin
            r_state <= DIV_FREE;
          end else begin
            r_state  <= DIV_END;
            r_ready  <= DIV_RESULT_READY;
            r_result <= r_rem_sel ? r_dividend : '1;
          end
        end

        DIV_ON: begin
          if (w_abort) begin
            r_state <= DIV_FREE;
            r_cnt   <= '0;
          end else begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_CNT) begin
              r_state  <= DIV_END;
              r_ready  <= DIV_RESULT_READY;
              r_result <= r_rem_sel ? w_rem_fixed : w_quo_fixed;
            end
          end
        end

        DIV_END: begin
          if (w_abort) begin
            r_state  <= DIV_FREE;
            r_ready  <= DIV_RESULT_NOT_READY;
            r_result <= '0;
            r_cnt    <= '0;
          end
        end

        default: begin
          r_state  <= DIV_FREE;
          r_ready  <= DIV_RESULT_NOT_READY;
          r_result <= '0;
        end
      endcase
    end
  end

  assign result_o    = r_result;
  assign ready_o     = r_ready;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: a driver issues operations with hand-computed
// expected results pushed into a queue; a monitor pops and compares each time
// ready_o rises. Latency, hold, drop, abort and reset behaviour are checked
// by the driver.
module tb_div_unit;
  import div_unit_pkg::*;

`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] opdata1_i, opdata2_i;
  logic        start_i, signed_i, rem_i, annul_i;
  logic [31:0] result_o;
  logic        ready_o;
  logic [1:0]  dbg_state_o;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  logic        mon_prev = 1'b0;

  div_unit #(.DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .opdata1_i   (opdata1_i),
    .opdata2_i   (opdata2_i),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .rem_i       (rem_i),
    .annul_i     (annul_i),
    .result_o    (result_o),
    .ready_o     (ready_o),
    .dbg_state_o (dbg_state_o)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare the result each time ready_o rises
  always @(negedge clk) begin
    if (ready_o && !mon_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 32'd1, 32'd0);
      end else begin
        check("result", result_o, exp_q.pop_front());
      end
    end
    mon_prev = ready_o;
  end

  // Driver: issue one operation, check latency, optional hold, then drop start
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                       input logic rem, input logic [31:0] exp, input int lat, input int hold);
    int  edges;
    bit  got;
    @(negedge clk);
    opdata1_i = a; opdata2_i = b; signed_i = sgn; rem_i = rem; start_i = 1'b1;
    exp_q.push_back(exp);
    edges = 0; got = 0;
    while (!got && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (edges == 1) begin
        // Only the latched copies may matter from here on
        opdata1_i = $urandom; opdata2_i = $urandom;
        signed_i = 1'($urandom_range(0, 1)); rem_i = 1'($urandom_range(0, 1));
      end
      if (ready_o) got = 1;
    end
    if (!got) check("ready_timeout", 32'd0, 32'd1);
    else      check("latency", edges, lat);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_ready", {31'd0, ready_o}, 32'd1);
      check("hold_result", result_o, exp);
    end
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk); #1;
    check("drop_ready", {31'd0, ready_o}, 32'd0);
    check("drop_result", result_o, 32'd0);
  endtask

  // Main stimulus
  initial begin
    int rose;
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_i = 1'b0; rem_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {31'd0, ready_o}, 32'd0);
    check("reset_result", result_o, 32'd0);
    check("reset_state", {30'd0, dbg_state_o}, {30'd0, DIV_FREE});
    @(negedge clk);
    rst = 1'b0;

    // Signed and unsigned basics
    do_op(32'hFFFFFFF9, 32'h00000002, 1'b1, 1'b0, 32'hFFFFFFFD, 33, 2);
    do_op(32'hFFFFFFF9, 32'h00000002, 1'b1, 1'b1, 32'hFFFFFFFF, 33, 0);
    do_op(32'hFFFFFFFF, 32'h00000010, 1'b0, 1'b0, 32'h0FFFFFFF, 33, 0);
    do_op(32'hFFFFFFFF, 32'h00000010, 1'b0, 1'b1, 32'h0000000F, 33, 0);
    do_op(32'h00000007, 32'hFFFFFFFE, 1'b1, 1'b0, 32'hFFFFFFFD, 33, 0);
    do_op(32'h00000007, 32'hFFFFFFFE, 1'b1, 1'b1, 32'h00000001, 33, 0);
    do_op(32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 1'b0, 32'h00000003, 33, 0);
    do_op(32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 1'b1, 32'hFFFFFFFF, 33, 0);
    // Divide by zero
    do_op(32'h00000005, 32'h00000000, 1'b1, 1'b0, 32'hFFFFFFFF, 2, 1);
    do_op(32'h00000005, 32'h00000000, 1'b1, 1'b1, 32'h00000005, 2, 0);
    do_op(32'hFFFFFFFB, 32'h00000000, 1'b1, 1'b1, 32'hFFFFFFFB, 2, 0);
    // Signed overflow
    do_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h80000000, 33, 0);
    do_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h00000000, 33, 0);

    // Annul at iteration 10: no result, idle next edge
    @(negedge clk);
    opdata1_i = 32'd100; opdata2_i = 32'd7; signed_i = 1'b0; rem_i = 1'b0; start_i = 1'b1;
    rose = 0;
    repeat (11) begin
      @(posedge clk); #1;
      if (ready_o) rose = 1;
    end
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk); #1;
    check("annul_state", {30'd0, dbg_state_o}, {30'd0, DIV_FREE});
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_o) rose = 1;
    end
    check("annul_no_ready", rose, 32'd0);
    do_op(32'd3, 32'd1, 1'b0, 1'b0, 32'd3, 33, 0);

    // start_i dropped mid-iteration returns to idle
    @(negedge clk);
    opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk); #1;
    check("drop_mid_state", {30'd0, dbg_state_o}, {30'd0, DIV_FREE});
    check("drop_mid_ready", {31'd0, ready_o}, 32'd0);

    // Reset mid-operation
    @(negedge clk);
    start_i = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_ready", {31'd0, ready_o}, 32'd0);
    check("midrst_result", result_o, 32'd0);
    check("midrst_state", {30'd0, dbg_state_o}, {30'd0, DIV_FREE});
    @(negedge clk);
    rst = 1'b0; start_i = 1'b0;
    @(posedge clk);

    // Dividend magnitude below divisor
    do_op(32'd3, 32'd7, 1'b0, 1'b0, 32'd0, EARLY_LAT, 1);
    do_op(32'd3, 32'd7, 1'b0, 1'b1, 32'd3, EARLY_LAT, 0);
    do_op(32'hFFFFFFFD, 32'd7, 1'b1, 1'b1, 32'hFFFFFFFD, EARLY_LAT, 0);
    do_op(32'hFFFFFFFD, 32'd7, 1'b1, 1'b0, 32'd0, EARLY_LAT, 0);

    repeat (3) @(posedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
